// File: rtl/dequant_stream.sv
// dequant_stream: streaming multi-channel signed-int to fp32 dequantizer with a per-channel scale table
module dequant_stream #(
  parameter int IN_W = 32,
  parameter int NCH  = 4,
  parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_level,
  input  logic [CH_W-1:0] in_ch,
  input  logic            in_is_weight,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [CH_W-1:0] out_ch,
  output logic            out_ovfl,
  output logic            out_unfl,
  output logic            out_excp,
  input  logic            cfg_we,
  input  logic [CH_W:0]   cfg_addr,
  input  logic [31:0]     cfg_scale
);
  logic adv, v1, v2, v3, v4;
  logic [31:0] wtbl [NCH];
  logic [31:0] atbl [NCH];
  logic [CH_W-1:0] ch_m;
  logic [IN_W-1:0] a_lvl, b_mag, mag;
  logic [CH_W-1:0] a_ch, b_ch, c_ch, d_ch;
  logic [31:0] a_scl, b_scl, nrm, c_sdat, d_sdat;
  logic [4:0] lop, b_lop;
  logic b_neg, sgn, nan, lz, sz;
  logic [24:0] lsum;
  logic [5:0] c_exp;
  logic [23:0] c_sigl, c_sigs, msum;
  logic [7:0] c_se;
  logic c_sign, c_spc, d_sign, d_spc;
  logic [2:0] c_flg, d_flg;
  logic [47:0] d_prod;
  logic [9:0] d_exp, rexp;
  logic hi, rb, ovf;
  logic [22:0] fr;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign ch_m = (32'(in_ch) < NCH) ? in_ch : '0;
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        wtbl[i] <= 32'h3ABFFFE0;
        atbl[i] <= 32'h36200013;
      end else if (cfg_we && 32'(cfg_addr[CH_W-1:0]) == i) begin
        if (cfg_addr[CH_W]) wtbl[i] <= cfg_scale;
        else atbl[i] <= cfg_scale;
      end
    end
  // magnitude is unsigned IN_W bits so the most negative level converts correctly
  always_comb begin
    mag = a_lvl[IN_W-1] ? -a_lvl : a_lvl;
    lop = '0;
    for (int i = 0; i < IN_W; i++) if (mag[i]) lop = 5'(i);
  end
  always_comb begin
    nrm = 32'(b_mag) << (5'd31 - b_lop);
    lsum = {1'b0, nrm[31:8]} + 25'(nrm[7] && (nrm[8] || |nrm[6:0]));
    sgn = b_neg ^ b_scl[31];
    nan = &b_scl[30:23];
    lz = b_mag == '0;
    sz = b_scl[30:23] == 8'd0;
  end
  // product of two [1,2) significands lies in [1,4); hidden bit is dropped before rounding
  always_comb begin
    hi = d_prod[47];
    fr = hi ? d_prod[46:24] : d_prod[45:23];
    rb = hi ? d_prod[23] && (d_prod[24] || |d_prod[22:0]) : d_prod[22] && (d_prod[23] || |d_prod[21:0]);
    msum = {1'b0, fr} + 24'(rb);
    rexp = d_exp + 10'(hi) + 10'(msum[23]);
    ovf = rexp > 10'd254;
  end
  always_ff @(posedge clk)
    if (rst) begin
      {v1, v2, v3, v4, out_valid} <= '0;
      out_data <= '0;
      out_ch <= '0;
      {out_ovfl, out_unfl, out_excp} <= '0;
    end else if (adv) begin
      {v1, v2, v3, v4, out_valid} <= {in_valid, v1, v2, v3, v4};
      a_lvl <= in_level;
      a_ch <= in_ch;
      a_scl <= in_is_weight ? wtbl[ch_m] : atbl[ch_m];
      b_mag <= mag;
      b_lop <= lop;
      b_neg <= a_lvl[IN_W-1];
      b_scl <= a_scl;
      b_ch <= a_ch;
      c_exp <= 6'(b_lop) + 6'(lsum[24]);
      c_sigl <= lsum[24] ? 24'h800000 : lsum[23:0];
      c_sigs <= {1'b1, b_scl[22:0]};
      c_se <= b_scl[30:23];
      c_sign <= sgn;
      c_spc <= nan || lz || sz;
      c_sdat <= nan ? 32'h7FC00000 : lz ? 32'd0 : {sgn, 31'd0};
      c_flg <= {1'b0, !nan && !lz && sz && |b_scl[22:0], nan};
      c_ch <= b_ch;
      d_prod <= 48'(c_sigl) * 48'(c_sigs);
      d_exp <= 10'(c_exp) + 10'(c_se);
      d_sign <= c_sign;
      d_spc <= c_spc;
      d_sdat <= c_sdat;
      d_flg <= c_flg;
      d_ch <= c_ch;
      out_data <= d_spc ? d_sdat : ovf ? {d_sign, 8'hFF, 23'd0} : {d_sign, rexp[7:0], msum[22:0]};
      {out_ovfl, out_unfl, out_excp} <= d_spc ? d_flg : {ovf, 2'b00};
      out_ch <= d_ch;
    end
endmodule

// File: tb/tb_dequant_stream.sv
// tb_dequant_stream: directed bench with a real-arithmetic reference model and a streaming scoreboard
module tb_dequant_stream;
  logic clk = 0, rst = 1, in_valid = 0, in_is_weight = 0, out_ready = 1, cfg_we = 0;
  logic in_ready, out_valid, out_ovfl, out_unfl, out_excp;
  logic [31:0] in_level = 0, out_data, cfg_scale = 0;
  logic [1:0] in_ch = 0, out_ch;
  logic [2:0] cfg_addr = 0;
  int checks = 0, errors = 0, acc = 0, xfers = 0, oc = 0, best = 0, rl = 0;
  typedef struct packed { logic [31:0] d; logic [1:0] ch; logic [2:0] f; } exp_t;
  exp_t q[$];
  logic [31:0] mw [4];
  logic [31:0] ma [4];

  dequant_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level),
    .in_ch(in_ch), .in_is_weight(in_is_weight), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_ovfl(out_ovfl), .out_unfl(out_unfl),
    .out_excp(out_excp), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic real p2(int k);
    real r = 1.0;
    for (int i = 0; i < k; i++) r = r * 2.0;
    for (int i = 0; i > k; i--) r = r / 2.0;
    return r;
  endfunction

  // round positive x to a 24-bit significand (nearest even); value = q * 2^(e-23)
  function automatic void rnd24(real x, output int e, output int q);
    real m, t, fr;
    m = x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    t = m * 8388608.0;
    q = $rtoi(t);
    fr = t - q;
    if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
    if (q == 16777216) begin q = 8388608; e++; end
  endfunction

  function automatic exp_t model(int lvl, bit w, logic [1:0] ch);
    logic [31:0] s;
    exp_t r;
    int e, q, el, ql;
    real v;
    bit neg;
    s = w ? mw[ch] : ma[ch];
    r.ch = ch;
    r.f = 3'b000;
    r.d = 32'd0;
    neg = (lvl < 0) ^ s[31];
    if (s[30:23] == 8'hFF) begin
      r.d = 32'h7FC00000;
      r.f = 3'b001;
    end else if (lvl == 0) begin
      r.d = 32'd0;
    end else if (s[30:23] == 8'd0) begin
      r.d = {neg, 31'd0};
      r.f = {1'b0, s[22:0] != 0, 1'b0};
    end else begin
      rnd24((lvl < 0) ? -real'(lvl) : real'(lvl), el, ql);
      v = ql * p2(el - 23) * (8388608.0 + s[22:0]) * p2(int'(s[30:23]) - 150);
      rnd24(v, e, q);
      if (e + 127 > 254) begin
        r.d = {neg, 8'hFF, 23'd0};
        r.f = 3'b100;
      end else r.d = {neg, 8'(e + 127), 23'(q)};
    end
    return r;
  endfunction

  // scoreboard: sampled on the falling edge, describes the transfer at the next rising edge
  initial begin
    exp_t ex, ac, hold;
    bit held;
    held = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      ac = {out_data, out_ch, out_ovfl, out_unfl, out_excp};
      if (rst) begin
        q.delete();
        held = 0;
        acc = 0;
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
          mw[i] = 32'h3ABFFFE0;
          ma[i] = 32'h36200013;
        end
      end else begin
        if (held && out_valid) chk("stall_stable", ac, hold);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out act=%0h exp=none", ac);
          end else begin
            ex = q.pop_front();
            chk("stream", ac, ex);
            xfers++;
          end
        end
        held = out_valid && !out_ready;
        hold = ac;
        if (in_valid && in_ready) begin
          q.push_back(model(in_level, in_is_weight, in_ch));
          acc++;
        end
        if (cfg_we) begin
          if (cfg_addr[2]) mw[cfg_addr[1:0]] = cfg_scale;
          else ma[cfg_addr[1:0]] = cfg_scale;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int lvl, bit w, logic [1:0] ch);
    int n = 0;
    in_valid = 1;
    in_level = lvl;
    in_is_weight = w;
    in_ch = ch;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    tick();
    in_valid = 0;
  endtask

  task automatic cfg(logic [2:0] a, logic [31:0] d);
    cfg_we = 1;
    cfg_addr = a;
    cfg_scale = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic run1(string nm, int lvl, bit w, logic [1:0] ch, logic [31:0] d, logic [2:0] f);
    send(lvl, w, ch);
    repeat (3) tick();
    chk({nm, "_early"}, out_valid, 1'b0);
    tick();
    chk(nm, {out_valid, out_data, out_ch, out_ovfl, out_unfl, out_excp}, {1'b1, d, ch, f});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    exp_t e;
    repeat (3) tick();
    chk("reset_vals", {out_valid, out_data, out_ch, out_ovfl, out_unfl, out_excp}, '0);
    chk("reset_ready", in_ready, 1'b1);
    rst = 0;
    tick();
    e = model(14562, 1, 2'd0);
    chk("model_pin0", e.d, 32'h41AAA5E4);
    e = model(-1, 1, 2'd0);
    chk("model_pin1", e.d, 32'hBABFFFE0);
    run1("v14562_w0", 14562, 1, 0, 32'h41AAA5E4, 0);
    run1("v4096_w1", 4096, 1, 1, 32'h40BFFFE0, 0);
    run1("v4096_a2", 4096, 0, 2, 32'h3C200013, 0);
    run1("v0_w3", 0, 1, 3, 32'h00000000, 0);
    run1("vm1_w0", -1, 1, 0, 32'hBABFFFE0, 0);
    run1("vmin_w0", 32'h80000000, 1, 0, 32'hCA3FFFE0, 0);
    fork
      begin
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
          in_level = 1000 * i - 3000;
          in_is_weight = i[0];
          in_ch = 2'(i);
          @(negedge clk);
          if (!in_ready) rl++;
          tick();
        end
        in_valid = 0;
      end
      begin
        int run = 0;
        for (int j = 0; j < 16; j++) begin
          @(negedge clk);
          if (out_valid) begin
            oc++;
            run++;
            if (run > best) best = run;
          end else run = 0;
        end
      end
    join
    chk("b2b_count", oc, 8);
    chk("b2b_run", best, 8);
    chk("b2b_ready_low", rl, 0);
    tick();
    out_ready = 0;
    k = 0;
    in_valid = 1;
    while (k < 10) begin
      in_level = k + 1;
      in_is_weight = 1;
      in_ch = 0;
      @(negedge clk);
      if (!in_ready) break;
      tick();
      k++;
    end
    in_valid = 0;
    chk("stall_fill", k, 5);
    repeat (3) begin
      chk("stall_hold", {out_valid, in_ready, out_data}, {2'b10, 32'h3ABFFFE0});
      @(negedge clk);
    end
    tick();
    out_ready = 1;
    repeat (10) tick();
    chk("stall_drain", xfers, acc);
    cfg(3'b101, 32'h7F000000);
    run1("ovf_pos", 4, 1, 1, 32'h7F800000, 3'b100);
    run1("ovf_neg", -4, 1, 1, 32'hFF800000, 3'b100);
    cfg(3'b010, 32'h7FC00000);
    run1("nan_scale", 7, 0, 2, 32'h7FC00000, 3'b001);
    run1("nan_zero_lvl", 0, 0, 2, 32'h7FC00000, 3'b001);
    cfg(3'b010, 32'h00000001);
    run1("denorm", 5, 0, 2, 32'h00000000, 3'b010);
    cfg(3'b010, 32'h80000000);
    run1("neg_zero_scale", 5, 0, 2, 32'h80000000, 3'b000);
    cfg(3'b010, 32'hBF800000);
    run1("zero_level", 0, 0, 2, 32'h00000000, 3'b000);
    run1("neg_scale", 3, 0, 2, 32'hC0400000, 3'b000);
    cfg(3'b000, 32'h3F800000);
    run1("rne_tie_low", 16777217, 0, 0, 32'h4B800000, 0);
    run1("rne_tie_up", 16777219, 0, 0, 32'h4B800002, 0);
    cfg_we = 1;
    cfg_addr = 3'b011;
    cfg_scale = 32'h3F800000;
    run1("same_edge_old", 4096, 0, 3, 32'h3C200013, 0);
    cfg_we = 0;
    run1("later_new", 4096, 0, 3, 32'h45800000, 0);
    chk("delivered_pre_rst", xfers, acc);
    send(11, 1, 0);
    send(22, 0, 1);
    send(33, 1, 2);
    rst = 1;
    in_valid = 1;
    in_level = 4096;
    in_is_weight = 0;
    in_ch = 2;
    cfg_we = 1;
    cfg_addr = 3'b010;
    cfg_scale = 32'h3F800000;
    tick();
    chk("rst_ready", in_ready, 1'b1);
    tick();
    chk("rst_vals", {out_valid, out_data, out_ch, out_ovfl, out_unfl, out_excp}, '0);
    rst = 0;
    in_valid = 0;
    cfg_we = 0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("rst_drop", n, 0);
    tick();
    run1("post_rst", 4096, 0, 2, 32'h3C200013, 0);
    repeat (5) tick();
    chk("delivered", xfers, acc);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
